ddr_burst_scheduler: RTL



---
 rtl/ddr_sched_pkg.sv | 18 +
 rtl/ddr_burst_scheduler_sat_counter.sv | 24 ++
 rtl/ddr_burst_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ddr_sched_pkg.sv
// Shared state encoding and default tuning for the DDR request-port burst scheduler.
// Pure declarations: no logic, no latency.
package ddr_sched_pkg;

  typedef enum logic [1:0] {
    RST       = 2'd0,
    WAIT_INIT = 2'd1,
    RD        = 2'd2,
    WR        = 2'd3
  } sched_state_t;

  localparam int RD_BURST_DEF     = 16;
  localparam int WR_BURST_DEF     = 16;
  localparam int IDLE_SWITCH_DEF  = 4;
  localparam int STARVE_LIMIT_DEF = 64;
  localparam int CW_DEF           = 16;

endpackage

// File: rtl/ddr_burst_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// One-cycle update latency; holds its value when neither clr nor inc is asserted.
module sat_counter #(
  parameter int CW  = 16,
  parameter int MAX = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ddr_burst_scheduler.sv
// Burst arbiter deciding whether the read or the write stream owns the DDR request port.
// Grants follow the state register, so a switch decided this cycle takes effect next cycle.
module ddr_burst_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int RD_BURST     = RD_BURST_DEF,
  parameter int WR_BURST     = WR_BURST_DEF,
  parameter int IDLE_SWITCH  = IDLE_SWITCH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CW           = CW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_done,
  input  logic       rd_pending,
  input  logic       wr_pending,
  input  logic       rd_issue,
  input  logic       wr_issue,
  output logic       grant_rd,
  output logic       grant_wr,
  output logic [1:0] sched_state,
  output logic       forced_switch
);

  if (RD_BURST < 1 || WR_BURST < 1 || IDLE_SWITCH < 1 ||
      STARVE_LIMIT <= RD_BURST || STARVE_LIMIT <= WR_BURST ||
      RD_BURST >= (2**CW) || WR_BURST >= (2**CW) ||
      IDLE_SWITCH >= (2**CW) || STARVE_LIMIT >= (2**CW)) begin : g_bad_params
    $error("ddr_burst_scheduler: parameters out of range for CW-bit counters");
  end

  localparam logic [CW-1:0] RD_LAST     = CW'(RD_BURST - 1);
  localparam logic [CW-1:0] WR_LAST     = CW'(WR_BURST - 1);
  localparam logic [CW-1:0] IDLE_LAST   = CW'(IDLE_SWITCH - 1);
  localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_LIMIT - 1);

  sched_state_t  state;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] starve_cnt;

  logic          in_rd;
  logic          active;
  logic          own_pend;
  logic          oth_pend;
  logic          own_issue;
  logic [CW-1:0] burst_max;
  logic          burst_last;
  logic          idle_cond;
  logic          idle_hit;
  logic          starve_hit;
  logic          sw;
  logic          hold;
  logic          cnt_clr;
  logic          starve_clr;

  // Owner/other views let RD and WR share one set of switch rules.
  always_comb begin
    in_rd      = (state == RD);
    active     = (state == RD) || (state == WR);
    own_pend   = in_rd ? rd_pending : wr_pending;
    oth_pend   = in_rd ? wr_pending : rd_pending;
    own_issue  = in_rd ? rd_issue   : wr_issue;
    burst_max  = in_rd ? RD_LAST    : WR_LAST;
    burst_last = own_issue && (burst_cnt == burst_max);
    idle_cond  = !own_pend && oth_pend;
    idle_hit   = idle_cond && (idle_cnt == IDLE_LAST);
    starve_hit = oth_pend && (starve_cnt == STARVE_LAST);
    sw         = active && init_done && ((burst_last && oth_pend) || idle_hit || starve_hit);
    hold       = !own_pend && !oth_pend;
    cnt_clr    = !active || !init_done || sw;
    starve_clr = cnt_clr || (own_pend && !oth_pend);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RST;
      forced_switch <= 1'b0;
    end else begin
      forced_switch <= 1'b0;
      case (state)
        RST:       state <= WAIT_INIT;
        WAIT_INIT: if (init_done) state <= RD;
        RD, WR: begin
          if (!init_done) begin
            state <= WAIT_INIT;
          end else if (sw) begin
            if (in_rd) state <= WR;
            else       state <= RD;
            forced_switch <= starve_hit;
          end
        end
        default:   state <= RST;
      endcase
    end
  end

  // A burst that completes with nobody waiting simply starts a new tenure.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else if (!hold) begin
      if (own_issue) begin
        burst_cnt <= burst_last ? '0 : burst_cnt + CW'(1);
      end
      idle_cnt <= idle_cond ? idle_cnt + CW'(1) : '0;
    end
  end

  sat_counter #(
    .CW  (CW),
    .MAX (STARVE_LIMIT)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (starve_clr),
    .inc (oth_pend),
    .cnt (starve_cnt)
  );

  assign grant_rd    = (state == RD);
  assign grant_wr    = (state == WR);
  assign sched_state = state;

endmodule
